// File: rtl/uart_config_pkg.sv
// Shared UART configuration types, baud-rate table and divisor helper.
package uart_config_pkg;

  localparam int unsigned BitcntWidth = 3;
  localparam int unsigned NumBauds    = 7;

  localparam int unsigned BaudSel4800   = 0;
  localparam int unsigned BaudSel9600   = 1;
  localparam int unsigned BaudSel14400  = 2;
  localparam int unsigned BaudSel19200  = 3;
  localparam int unsigned BaudSel38400  = 4;
  localparam int unsigned BaudSel57600  = 5;
  localparam int unsigned BaudSel115200 = 6;

  localparam int unsigned BaudRate [NumBauds] = '{4800, 9600, 14400, 19200, 38400, 57600, 115200};

  typedef enum logic [2:0] {
    TxIdle           = 3'd0,
    TxStartBit       = 3'd1,
    TxSendData       = 3'd2,
    TxSendParity     = 3'd3,
    TxSendFirstStop  = 3'd4,
    TxSendSecondStop = 3'd5,
    TxDone           = 3'd6
  } tx_state_type;

  typedef enum logic {
    ParityEven = 1'b0,
    ParityOdd  = 1'b1
  } parity_type_t;

  typedef enum logic {
    StartBitCode = 1'b0,
    StopBitCode  = 1'b1
  } data_code_e;

  // Clocks per line bit, truncated.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned idx);
    return clk_hz / BaudRate[idx];
  endfunction

endpackage

// File: rtl/uart_baud_div.sv
// Bit-time generator: latches the divisor chosen by a one-hot select and strobes bit_end_o
// on the last clock of every bit period.
module uart_baud_div
  import uart_config_pkg::*;
#(
  parameter int unsigned ClkFreqHz = 50_000_000
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                load_i,
  input  logic [NumBauds-1:0] baud_sel_i,
  input  logic                restart_i,
  output logic                bit_end_o
);

  localparam int unsigned CntWidth = $clog2(baud_div(ClkFreqHz, BaudSel4800));

  for (genvar i = 0; i < NumBauds; i++) begin : g_div_check
    if (baud_div(ClkFreqHz, i) < 2) begin : g_bad
      $error("uart_baud_div: divisor below 2 for baud index %0d", i);
    end
  end

  logic [CntWidth-1:0] div_m1_d, div_m1_q;
  logic [CntWidth-1:0] cnt_d, cnt_q;
  logic                sel_onehot;

  // Anything other than exactly one select bit falls back to 9600.
  always_comb begin
    sel_onehot = (baud_sel_i != '0) &&
                 ((baud_sel_i & (baud_sel_i - NumBauds'(1))) == '0);
    div_m1_d   = CntWidth'(baud_div(ClkFreqHz, BaudSel9600) - 1);
    if (sel_onehot) begin
      for (int unsigned i = 0; i < NumBauds; i++) begin
        if (baud_sel_i[i]) begin
          div_m1_d = CntWidth'(baud_div(ClkFreqHz, i) - 1);
        end
      end
    end
  end

  assign bit_end_o = (cnt_q == div_m1_q);

  always_comb begin
    cnt_d = cnt_q + CntWidth'(1);
    if (restart_i || bit_end_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q    <= '0;
      div_m1_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (load_i) begin
        div_m1_q <= div_m1_d;
      end
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit serialiser: start bit, 1..8 data bits LSB-first, optional parity, 1 or 2 stops.
// Accepts one character per valid/ready handshake; txd is registered.
module uart_tx_framer
  import uart_config_pkg::*;
#(
  parameter int unsigned ClkFreqHz = 50_000_000,
  parameter int unsigned DataWidth = 8
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [DataWidth-1:0]   tx_data_i,
  input  logic                   tx_valid_i,
  output logic                   tx_ready_o,
  input  logic [BitcntWidth-1:0] trans_len_i,
  input  logic                   parity_en_i,
  input  parity_type_t           parity_type_i,
  input  logic                   two_stop_i,
  input  logic [NumBauds-1:0]    baud_sel_i,
  output logic                   txd_o,
  output logic                   tx_busy_o,
  output logic                   tx_done_o
);

  tx_state_type           state_d, state_q;
  logic [BitcntWidth-1:0] idx_d, idx_q;
  logic                   txd_d, txd_q;

  logic [DataWidth-1:0]   data_q;
  logic [BitcntWidth-1:0] len_q;
  logic                   par_en_q;
  parity_type_t           par_type_q;
  logic                   two_stop_q;

  logic                   accept;
  logic                   bit_end;
  logic                   restart;
  logic [DataWidth-1:0]   data_mask;
  logic                   parity_bit;

  assign accept = tx_valid_i && (state_q == TxIdle);

  uart_baud_div #(
    .ClkFreqHz (ClkFreqHz)
  ) u_baud_div (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .load_i     (accept),
    .baud_sel_i (baud_sel_i),
    .restart_i  (restart),
    .bit_end_o  (bit_end)
  );

  // Only the trans_len+1 transmitted bits take part in the parity.
  always_comb begin
    data_mask = '0;
    for (int unsigned i = 0; i < DataWidth; i++) begin
      data_mask[i] = (i <= 32'(len_q));
    end
    parity_bit = (^(data_q & data_mask)) ^ (par_type_q == ParityOdd);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      TxIdle: begin
        if (accept) begin
          state_d = TxStartBit;
        end
      end
      TxStartBit: begin
        if (bit_end) begin
          state_d = TxSendData;
          idx_d   = '0;
        end
      end
      TxSendData: begin
        if (bit_end) begin
          if (idx_q == len_q) begin
            state_d = par_en_q ? TxSendParity : TxSendFirstStop;
          end else begin
            idx_d = idx_q + BitcntWidth'(1);
          end
        end
      end
      TxSendParity: begin
        if (bit_end) begin
          state_d = TxSendFirstStop;
        end
      end
      TxSendFirstStop: begin
        if (bit_end) begin
          state_d = two_stop_q ? TxSendSecondStop : TxDone;
        end
      end
      TxSendSecondStop: begin
        if (bit_end) begin
          state_d = TxDone;
        end
      end
      TxDone:  state_d = TxIdle;
      default: state_d = TxIdle;
    endcase

    // Line value follows the state being entered so txd and state change on the same edge.
    case (state_d)
      TxStartBit:   txd_d = StartBitCode;
      TxSendData:   txd_d = data_q[idx_d];
      TxSendParity: txd_d = parity_bit;
      default:      txd_d = StopBitCode;
    endcase
  end

  assign restart = (state_d != state_q);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= TxIdle;
      idx_q      <= '0;
      txd_q      <= StopBitCode;
      data_q     <= '0;
      len_q      <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= ParityEven;
      two_stop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      txd_q   <= txd_d;
      if (accept) begin
        data_q     <= tx_data_i;
        len_q      <= trans_len_i;
        par_en_q   <= parity_en_i;
        par_type_q <= parity_type_i;
        two_stop_q <= two_stop_i;
      end
    end
  end

  assign txd_o      = txd_q;
  assign tx_ready_o = (state_q == TxIdle);
  assign tx_done_o  = (state_q == TxDone);
  assign tx_busy_o  = (state_q != TxIdle) && (state_q != TxDone);

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- Transmit-side serialiser of the UART. Accepts one parallel character per valid/ready handshake and drives the serial TxD line: start bit, 1..8 data bits LSB-first, optional parity, then 1 or 2 stop bits.
- Baud timing is generated internally from the system clock and a one-hot baudrate select.
- Sits directly downstream of the TX FIFO (depth TX_FIFO_DEPTH) and drives the top-level txd pin.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency. Per-baud divisors are computed from it at elaboration.
- DATA_WIDTH, 8, width of the tx_data port. Maximum character length.

Ports:
- clk, input, 1, system clock.
- rstn, input, 1, asynchronous active-low reset.
- tx_data, input, DATA_WIDTH, character to send. Sampled on handshake.
- tx_valid, input, 1, upstream has a character.
- tx_ready, output, 1, framer can accept. High only in TX_IDLE.
- trans_len, input, BITCNT_WIDTH, number of data bits minus 1 (0 → 1 bit, 7 → 8 bits). Sampled on handshake.
- parity_en, input, 1, insert parity bit. Sampled on handshake.
- parity_type, input, 1, parity_type_t (EVEN/ODD). Sampled on handshake.
- two_stop, input, 1, send second stop bit. Sampled on handshake.
- baud_sel, input, 7, one-hot baudrate select, indexed by BAUDRATE_SEL_*. Sampled on handshake.
- txd, output, 1, serial line. Idles at STOP_BIT_CODE.
- tx_busy, output, 1, high from handshake until return to TX_IDLE.
- tx_done, output, 1, one-cycle pulse in TX_DONE.

Behaviour:
- Reset, asynchronous:
  - state = TX_IDLE, txd = 1, tx_ready = 1, tx_busy = 0, tx_done = 0.
  - All counters and latched configuration are cleared.
  - Reset asserted mid-frame aborts the frame immediately and drives txd high. No tx_done is issued.
- Handshake:
  - Accept when tx_valid && tx_ready at a clk edge.
  - tx_data, trans_len, parity settings, two_stop and the resolved divisor are latched at that edge.
  - Input changes after the accept edge have no effect on the frame in progress.
  - tx_ready drops the cycle after acceptance. The next accept is possible no earlier than the cycle after TX_DONE.
- Baud divisor:
  - DIV[i] = CLK_FREQ_HZ / rate[i], truncated, for rates 4800, 9600, 14400, 19200, 38400, 57600, 115200.
  - If baud_sel is not exactly one-hot (zero or multiple bits set), the 9600 divisor is used.
  - Elaboration assertion: every DIV >= 2.
  - Bit counter width = $clog2(DIV[4800]).
- Bit-time counter:
  - Reloads to 0 on each state entry.
  - The bit ends when the counter reaches DIV-1; the transition happens on that edge.
  - Each line bit is held exactly DIV clocks.
- FSM, tx_state_type:
  - TX_IDLE: txd = 1. On accept → TX_START_BIT.
  - TX_START_BIT: txd = START_BIT_CODE. After DIV → TX_SEND_DATA, data index = 0.
  - TX_SEND_DATA: txd = data[index]. Each DIV increments the index. After index == trans_len completes → TX_SEND_PARITY if parity_en, else TX_SEND_FIRST_STOP.
  - TX_SEND_PARITY:
    - EVEN: txd = XOR of the trans_len+1 sent bits.
    - ODD: the inverted XOR.
    - Unsent upper bits are excluded. After DIV → TX_SEND_FIRST_STOP.
  - TX_SEND_FIRST_STOP: txd = 1. After DIV → TX_SEND_SECOND_STOP if two_stop, else TX_DONE.
  - TX_SEND_SECOND_STOP: txd = 1. After DIV → TX_DONE.
  - TX_DONE: txd = 1, tx_done = 1 for exactly one cycle, tx_busy = 0 → TX_IDLE.
  - Unused encoding 7 → TX_IDLE.
- txd is registered. It changes on the same edge the state changes.
- Latency: the first start-bit clock is the cycle after the accept edge.
- Frame length = (1 + trans_len+1 + parity_en + 1 + two_stop) × DIV clocks, plus 1 clock for TX_DONE.
- tx_valid held high continuously gives back-to-back frames separated by the TX_DONE and TX_IDLE cycles, 2 clocks of idle-high.

Decomposition:
- Already in uart_config_pkg: tx_state_type, parity_type_t, dataCode_e, baudrate select indices, BITCNT_WIDTH.
- Add to the package: baudrate value table (localparam array of 7 rates) and a function baud_div(clk_hz, idx).
- Sub-module uart_baud_div:
  - Holds the divisor-select register and bit-time counter.
  - Outputs a one-cycle bit_end strobe.
  - Input restart reloads the counter on each state entry.
  - Reused later by the RX side with RXD_SAMPLE_RATE.

Test Plan (CLK_FREQ_HZ = 1_152_000, so DIV = 10 at 115200 and 120 at 9600):
- Reset: pulse rstn low mid-frame → txd = 1, tx_ready = 1 and tx_busy = 0 asynchronously; no tx_done.
- 8N1 frame: tx_data = 0xA5, trans_len = 7, no parity, 1 stop, baud_sel = bit6 → txd reads 0,1,0,1,0,0,1,0,1,1, each for 10 clocks; tx_done pulses at clock 101 after accept.
- Parity and stop bits: 0x03 at 7-bit length (trans_len = 6), EVEN parity, two_stop → parity bit 0 and 11 line bits; the same with ODD → parity bit 1.
- Invalid baud_sel: baud_sel = 7'b0000011 and baud_sel = 0 → each bit lasts 120 clocks (9600 fallback).
- Back-to-back: tx_valid held high with 3 characters, 0x00/0xFF/0x55 → three frames, txd high for exactly 2 clocks between frames; changing tx_data mid-frame does not affect the current frame.
- Minimum length: trans_len = 0, data bit 1, ODD parity → txd reads 0,1,0,1, each 10 clocks.
